// File: rtl/updown_sweep_controller_if.sv
// Host-side bundle for the triangle sweep controller: launch/abort controls,
// latched bounds, and the exported count/direction/status.
interface updown_sweep_controller_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCW   = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo_bound;
  logic [WIDTH-1:0] hi_bound;
  logic [NCW-1:0]   num_sweeps;
  logic [WIDTH-1:0] count;
  logic             up_down;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             cfg_err;
  logic [NCW-1:0]   sweeps_done;

  modport master (
    output start, abort, lo_bound, hi_bound, num_sweeps,
    input  count, up_down, busy, done, aborted, cfg_err, sweeps_done
  );

  modport slave (
    input  start, abort, lo_bound, hi_bound, num_sweeps,
    output count, up_down, busy, done, aborted, cfg_err, sweeps_done
  );
endinterface

// File: rtl/updown_sweep_controller.sv
// Bounded triangle-sweep sequencer: ramps the owned count register lo->hi->lo
// for a latched number of sweeps (0 = free-run) with start/done/abort handshake.
module updown_sweep_controller #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCW   = 8
) (
  input logic                  clk,
  input logic                  reset,
  updown_sweep_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [NCW-1:0]   num_q, num_n;
  logic [NCW-1:0]   sweeps_q, sweeps_n;
  logic [NCW-1:0]   sweeps_inc;
  logic             done_q, done_n;
  logic             aborted_q, aborted_n;
  logic             cfg_err_q, cfg_err_n;
  logic             up_down_q, busy_q;

  assign sweeps_inc = sweeps_q + NCW'(1);

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      num_q     <= '0;
      sweeps_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
      up_down_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      lo_q      <= lo_n;
      hi_q      <= hi_n;
      num_q     <= num_n;
      sweeps_q  <= sweeps_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
      cfg_err_q <= cfg_err_n;
      up_down_q <= (state_n == S_UP);
      busy_q    <= (state_n == S_UP) || (state_n == S_DOWN);
    end
  end

  // Next-state and datapath; abort outranks the turn/completion checks.
  always_comb begin
    state_n   = state_q;
    count_n   = count_q;
    lo_n      = lo_q;
    hi_n      = hi_q;
    num_n     = num_q;
    sweeps_n  = sweeps_q;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    cfg_err_n = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.lo_bound < bus.hi_bound) begin
            lo_n     = bus.lo_bound;
            hi_n     = bus.hi_bound;
            num_n    = bus.num_sweeps;
            count_n  = bus.lo_bound;
            sweeps_n = '0;
            state_n  = S_UP;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      S_UP: begin
        if (bus.abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (count_q == hi_q) begin
          count_n = count_q - WIDTH'(1);
          state_n = S_DOWN;
        end else begin
          count_n = count_q + WIDTH'(1);
        end
      end
      S_DOWN: begin
        if (bus.abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (count_q != lo_q) begin
          count_n = count_q - WIDTH'(1);
        end else begin
          sweeps_n = sweeps_inc;
          if ((num_q != '0) && (sweeps_inc == num_q)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            count_n = count_q + WIDTH'(1);
            state_n = S_UP;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.count       = count_q;
  assign bus.up_down     = up_down_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.sweeps_done = sweeps_q;

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Directed bench for updown_sweep_controller: vector table for the basic sweep
// and bound rejects, hand sequences for full range, free-run wrap, abort, reset.
module tb_updown_sweep_controller;

  logic clk;
  logic reset;

  updown_sweep_controller_if #(.WIDTH(4), .NCW(8)) bus ();

  updown_sweep_controller #(.WIDTH(4), .NCW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed vector: {count, up_down, busy, done, aborted, cfg_err, sweeps_done}
  typedef struct {
    logic        start;
    logic        abort;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [7:0]  num;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [16:0] ev(input logic [3:0] c, input logic ud, input logic bz,
                                     input logic dn, input logic ab, input logic ce,
                                     input logic [7:0] sw);
    return {c, ud, bz, dn, ab, ce, sw};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.count, bus.up_down, bus.busy, bus.done, bus.aborted, bus.cfg_err, bus.sweeps_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [16:0] act, input logic [16:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%05h expected 0x%05h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic [3:0] lo, input logic [3:0] hi,
                       input logic [7:0] num);
    bus.start      = s;
    bus.abort      = a;
    bus.lo_bound   = lo;
    bus.hi_bound   = hi;
    bus.num_sweeps = num;
  endtask

  initial begin
    logic [3:0]  ec;
    logic        eud;
    logic [7:0]  esw;
    logic [7:0]  prev_sw;
    logic        saw_wrap;
    int          q;

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 8'd0);

    // Basic sweep lo=2 hi=4 num=1, then rejected starts and an idle abort.
    tbl[0]  = '{1'b1, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd2, 1, 1, 0, 0, 0, 8'd0)};
    tbl[1]  = '{1'b0, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd3, 1, 1, 0, 0, 0, 8'd0)};
    tbl[2]  = '{1'b0, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd4, 1, 1, 0, 0, 0, 8'd0)};
    tbl[3]  = '{1'b0, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd3, 0, 1, 0, 0, 0, 8'd0)};
    tbl[4]  = '{1'b0, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd2, 0, 1, 0, 0, 0, 8'd0)};
    tbl[5]  = '{1'b0, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd2, 0, 0, 1, 0, 0, 8'd1)};
    tbl[6]  = '{1'b0, 1'b0, 4'd2, 4'd4, 8'd1, ev(4'd2, 0, 0, 0, 0, 0, 8'd1)};
    tbl[7]  = '{1'b1, 1'b0, 4'd5, 4'd5, 8'd3, ev(4'd2, 0, 0, 0, 0, 1, 8'd1)};
    tbl[8]  = '{1'b0, 1'b0, 4'd5, 4'd5, 8'd3, ev(4'd2, 0, 0, 0, 0, 0, 8'd1)};
    tbl[9]  = '{1'b1, 1'b0, 4'd9, 4'd3, 8'd3, ev(4'd2, 0, 0, 0, 0, 1, 8'd1)};
    tbl[10] = '{1'b0, 1'b0, 4'd9, 4'd3, 8'd3, ev(4'd2, 0, 0, 0, 0, 0, 8'd1)};
    tbl[11] = '{1'b0, 1'b1, 4'd0, 4'd9, 8'd3, ev(4'd2, 0, 0, 0, 0, 0, 8'd1)};

    // Reset state, both while held and right after release.
    tick();
    tick();
    chk("reset_held", 0, obs(), ev(4'd0, 0, 0, 0, 0, 0, 8'd0));
    reset = 1'b0;
    tick();
    chk("reset_release", 0, obs(), ev(4'd0, 0, 0, 0, 0, 0, 8'd0));

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].start, tbl[i].abort, tbl[i].lo, tbl[i].hi, tbl[i].num);
      tick();
      chk("table", i, obs(), tbl[i].exp);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
    tick();

    // Full-range triangle lo=0 hi=15 num=2; done lands on cycle 62.
    drive(1'b1, 1'b0, 4'd0, 4'd15, 8'd2);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 61; c++) begin
      if (c == 1) begin
        ec = 4'd0; eud = 1'b1;
      end else begin
        q = (c - 2) % 30;
        if (q <= 14) begin
          ec = 4'(q + 1); eud = 1'b1;
        end else begin
          ec = 4'(29 - q); eud = 1'b0;
        end
      end
      esw = (c <= 31) ? 8'd0 : 8'd1;
      chk("full_range", c, obs(), ev(ec, eud, 1, 0, 0, 0, esw));
      tick();
    end
    chk("full_range_done", 62, obs(), ev(4'd0, 0, 0, 1, 0, 0, 8'd2));
    tick();
    chk("full_range_idle", 63, obs(), ev(4'd0, 0, 0, 0, 0, 0, 8'd2));

    // Free-run lo=1 hi=2: sweeps_done wraps; mid-run start/bound changes ignored.
    drive(1'b1, 1'b0, 4'd1, 4'd2, 8'd0);
    tick();
    bus.start = 1'b0;
    prev_sw  = 8'd0;
    saw_wrap = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      ec  = (c % 2 == 0) ? 4'd2 : 4'd1;
      eud = (c == 1) || (c % 2 == 0);
      esw = (c >= 2) ? 8'(((c - 2) / 2) % 256) : 8'd0;
      chk("free_run", c, obs(), ev(ec, eud, 1, 0, 0, 0, esw));
      if (prev_sw == 8'd255 && bus.sweeps_done == 8'd0) saw_wrap = 1'b1;
      prev_sw = bus.sweeps_done;
      if (c == 100) drive(1'b1, 1'b0, 4'd0, 4'd15, 8'd5);
      if (c == 101) bus.start = 1'b0;
      if (c == 600) bus.abort = 1'b1;
      if (c < 600) tick();
    end
    chk("free_run_wrap", 0, 17'(saw_wrap), 17'd1);
    // Abort on the cycle count==hi in UP: freeze at hi, no done.
    tick();
    bus.abort = 1'b0;
    chk("abort_at_hi", 601, obs(), ev(4'd2, 0, 0, 0, 1, 0, 8'd43));
    tick();
    chk("abort_after", 602, obs(), ev(4'd2, 0, 0, 0, 0, 0, 8'd43));

    // Reset while in DOWN, then a clean start and a start ignored in DONE.
    drive(1'b1, 1'b0, 4'd3, 4'd6, 8'd3);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      ec = (c <= 4) ? 4'(2 + c) : 4'd5;
      chk("pre_reset", c, obs(), ev(ec, (c <= 4), 1, 0, 0, 0, 8'd0));
      if (c < 5) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset", 0, obs(), ev(4'd0, 0, 0, 0, 0, 0, 8'd0));
    drive(1'b1, 1'b0, 4'd1, 4'd3, 8'd1);
    tick();
    bus.start = 1'b0;
    chk("restart", 1, obs(), ev(4'd1, 1, 1, 0, 0, 0, 8'd0));
    for (int c = 2; c <= 5; c++) tick();
    chk("restart", 5, obs(), ev(4'd1, 0, 1, 0, 0, 0, 8'd0));
    tick();
    chk("restart_done", 6, obs(), ev(4'd1, 0, 0, 1, 0, 0, 8'd1));
    drive(1'b1, 1'b0, 4'd0, 4'd9, 8'd2);
    tick();
    bus.start = 1'b0;
    chk("start_in_done", 7, obs(), ev(4'd1, 0, 0, 0, 0, 0, 8'd1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_sweep_controller.md
Name: updown_sweep_controller

Overview:
Sequencer that drives an up/down counter datapath as a bounded triangle sweep. The counter ramps from a programmed low bound to a high bound and back, for a programmed number of sweeps or until aborted. A start/done handshake lets a host (test-pattern or PWM/scan logic) launch sweeps. The block owns the count register and the direction control, and exports both to downstream logic.

Parameters:
WIDTH, 4, width of count and bound values
NCW, 8, width of sweep-count request and sweep counter

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a sweep run; sampled only in IDLE
abort  input  1  terminate an active run
lo_bound  input  WIDTH  sweep low bound; latched on accepted start
hi_bound  input  WIDTH  sweep high bound; latched on accepted start
num_sweeps  input  NCW  sweeps to run; 0 = free-run until abort; latched on accepted start
count  output  WIDTH  current counter value
up_down  output  1  1 = counting up, 0 = counting down/idle
busy  output  1  high in UP or DOWN
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse when a run is terminated by abort
cfg_err  output  1  one-cycle pulse when start is rejected
sweeps_done  output  NCW  completed sweeps in current/last run

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE, count=0, up_down=0, busy=0, done=0, aborted=0, cfg_err=0, sweeps_done=0, latched bounds=0.
- States: IDLE, UP, DOWN, DONE. busy = (UP|DOWN). up_down = (state==UP).
- IDLE with start=1:
  - If lo_bound < hi_bound: latch lo/hi/num_sweeps, count<=lo_bound, sweeps_done<=0, go to UP.
  - Else: cfg_err=1 for one cycle, stay IDLE, count unchanged.
- IDLE with start=0: count holds.
- UP: if count==hi_l then count<=count-1 and go to DOWN; else count<=count+1. Direction change has no dwell, so hi is present for exactly one cycle.
- DOWN when count!=lo_l: count<=count-1.
- DOWN when count==lo_l:
  - sweeps_done<=sweeps_done+1.
  - If num_l!=0 and sweeps_done+1==num_l: go to DONE, count holds.
  - Else: count<=count+1 and go to UP.
- DONE: done=1 for this single cycle, count holds at lo_l, next state IDLE.
- Timing: one sweep = 2*(hi-lo) cycles. done is asserted in the cycle 2*(hi-lo)*num+2 after the start-accept edge (at cycle 1 count=lo).
- abort in UP or DOWN: next cycle state=IDLE, aborted=1 for one cycle, count and sweeps_done frozen at current value, no done. abort has priority over the bound-turn and completion checks in the same cycle. abort in IDLE or DONE is ignored (DONE still completes normally).
- start while busy or in DONE: ignored, no error.
- Bound inputs change mid-run: no effect; only latched values are used.
- Free-run (num=0): sweeps_done wraps 2^NCW-1 -> 0 and the run continues.
- Arithmetic: count never leaves [lo_l, hi_l] while busy, so no modular wrap. lo=0 and hi=2^WIDTH-1 are legal.
- Mid-run reset returns to the reset state next edge with no done/aborted pulse.

Test Plan:
- Reset, then start with lo=2, hi=4, num=1 -> count 2,3,4,3,2 on cycles 1-5 (up_down 1,1,1,0,0). done=1 on cycle 6 with count=2 and sweeps_done=1. IDLE on cycle 7.
- Start with lo=0, hi=15, num=2 -> full-range triangle with no wrap past 15 or 0. done at cycle 62. sweeps_done=2.
- Start with lo=5, hi=5, and separately lo=9, hi=3 -> cfg_err one-cycle pulse each time, busy stays 0, count unchanged.
- num=0, lo=1, hi=2, run 600 cycles -> continuous 1,2,1,2 pattern. sweeps_done wraps past 255. Then abort -> aborted pulse and count frozen.
- Abort asserted on the same cycle count==hi in UP -> IDLE next cycle, count=hi, no done. Separately: start pulsed during a run is ignored, and changing bounds mid-run has no effect on the sweep.
- Reset asserted mid-DOWN -> next cycle count=0, all flags 0, state IDLE. A start on the following cycle is accepted normally.
